// File: rtl/dz_countdown.sv
// dz_countdown
// Countdown sequencer feeding the 3-bit digit code of the dot-matrix display.
// Counts START_VAL down to 0, one step every TICK_DIV clocks, under control of
// two push-button keys (start/pause and clear).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   key_start  raw start/pause key level (asynchronous, active-high)
//   key_clr    raw clear key level (asynchronous, active-high)
//   num        current count value, registered
//   running    high while the sequencer is in RUN, registered
//   done       one-cycle pulse when the count reaches 0, registered
//
// Key events are single-cycle pulses with no valid/ready handshake: a key that
// rises before edge N produces an event that is acted on at edge N+2 (two
// synchroniser flops, then the edge detector compares against a delay flop).
// Holding a key yields exactly one event.

module dz_countdown #(
  parameter int START_VAL = 5,
  parameter int TICK_DIV  = 1_000_000,
  parameter int DIV_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_clr,
  output logic [2:0] num,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0]       START_NUM = 3'(START_VAL);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);

  // Key synchronisers and edge detectors
  logic start_s1, start_s2, start_d;
  logic clr_s1, clr_s2, clr_d;
  logic start_evt, clr_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
      clr_s1   <= 1'b0;
      clr_s2   <= 1'b0;
      clr_d    <= 1'b0;
    end else begin
      start_s1 <= key_start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
      clr_s1   <= key_clr;
      clr_s2   <= clr_s1;
      clr_d    <= clr_s2;
    end
  end

  assign start_evt = start_s2 & ~start_d;
  assign clr_evt   = clr_s2 & ~clr_d;

  // FSM and datapath registers
  state_t           state, state_n;
  logic [DIV_W-1:0] pre, pre_n;
  logic [2:0]       num_n;
  logic             done_n;
  logic             running_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pre     <= '0;
      num     <= START_NUM;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      num     <= num_n;
      running <= running_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = pre;
    num_n   = num;
    done_n  = 1'b0;

    if (clr_evt) begin
      // Clear beats both start and tick in the same cycle.
      state_n = S_IDLE;
      pre_n   = '0;
      num_n   = START_NUM;
    end else begin
      unique case (state)
        S_IDLE: begin
          pre_n = '0;
          num_n = START_NUM;
          if (start_evt) begin
            if (START_VAL == 0) begin
              state_n = S_DONE;
              num_n   = 3'd0;
              done_n  = 1'b1;
            end else begin
              state_n = S_RUN;
            end
          end
        end

        S_RUN: begin
          if (pre == DIV_LAST) begin
            pre_n = '0;
            if (num <= 3'd1) begin
              // Reaching zero wins over a simultaneous start/pause request.
              state_n = S_DONE;
              num_n   = 3'd0;
              done_n  = 1'b1;
            end else begin
              num_n = num - 3'd1;
              if (start_evt) state_n = S_PAUSE;
            end
          end else begin
            // The prescaler still advances on the pausing clock, so a resume
            // continues exactly where this step left off.
            pre_n = pre + DIV_W'(1);
            if (start_evt) state_n = S_PAUSE;
          end
        end

        S_PAUSE: begin
          if (start_evt) state_n = S_RUN;
        end

        S_DONE: begin
          pre_n = '0;
          num_n = 3'd0;
          if (start_evt) begin
            state_n = S_RUN;
            num_n   = START_NUM;
          end
        end

        default: begin
          state_n = S_IDLE;
          pre_n   = '0;
          num_n   = START_NUM;
        end
      endcase
    end

    // Registering the next-state decode keeps running aligned with state.
    running_n = (state_n == S_RUN);
  end

endmodule

// File: tb/tb_dz_countdown.sv
// Bench for dz_countdown with TICK_DIV=4, START_VAL=5.
// Each clock, the expected {num, running, done} triple is pushed when the
// stimulus for that stretch is driven, then popped and compared against the
// DUT one cycle at a time on the falling edge.

module tb_dz_countdown;

  localparam int W = 5;

  logic       clk;
  logic       rst;
  logic       key_start;
  logic       key_clr;
  logic [2:0] num;
  logic       running;
  logic       done;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  dz_countdown #(
    .START_VAL(5),
    .TICK_DIV (4),
    .DIV_W    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_start(key_start),
    .key_clr  (key_clr),
    .num      (num),
    .running  (running),
    .done     (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Push n copies of an expected output triple, then clock them out and
  // compare one per cycle (sampled on the falling edge).
  task automatic cyc(input string tag, input int n, input logic [2:0] e_num,
                     input logic e_run, input logic e_done);
    for (int i = 0; i < n; i++) exp_q.push_back({e_num, e_run, e_done});
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, {num, running, done}, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    key_start = 1'b0;
    key_clr   = 1'b0;
    rst       = 1'b0;
    #1;
    check("reset_state", {num, running, done}, {3'd5, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Count from 5 down to done with RUN entered at the first sampled cycle.
  task automatic full_count(input string tag);
    cyc(tag, 4, 3'd5, 1'b1, 1'b0);
    cyc(tag, 4, 3'd4, 1'b1, 1'b0);
    cyc(tag, 4, 3'd3, 1'b1, 1'b0);
    cyc(tag, 4, 3'd2, 1'b1, 1'b0);
    cyc(tag, 4, 3'd1, 1'b1, 1'b0);
    cyc(tag, 1, 3'd0, 1'b0, 1'b1);
    cyc(tag, 3, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    key_start = 1'b0;
    key_clr   = 1'b0;

    // 1: plain countdown
    do_reset();
    key_start = 1'b1;
    cyc("t1_sync", 2, 3'd5, 1'b0, 1'b0);
    key_start = 1'b0;
    full_count("t1_count");

    // 2: pause and resume
    do_reset();
    key_start = 1'b1;
    cyc("t2_sync", 2, 3'd5, 1'b0, 1'b0);
    key_start = 1'b0;
    cyc("t2_run5", 4, 3'd5, 1'b1, 1'b0);
    key_start = 1'b1;
    cyc("t2_run4", 2, 3'd4, 1'b1, 1'b0);
    key_start = 1'b0;
    cyc("t2_pause", 8, 3'd4, 1'b0, 1'b0);
    key_start = 1'b1;
    cyc("t2_pause", 2, 3'd4, 1'b0, 1'b0);
    key_start = 1'b0;
    cyc("t2_resume", 2, 3'd4, 1'b1, 1'b0);
    cyc("t2_run3", 4, 3'd3, 1'b1, 1'b0);
    cyc("t2_run2", 4, 3'd2, 1'b1, 1'b0);
    cyc("t2_run1", 4, 3'd1, 1'b1, 1'b0);
    cyc("t2_done", 1, 3'd0, 1'b0, 1'b1);
    cyc("t2_after", 2, 3'd0, 1'b0, 1'b0);

    // 3: held key gives one event only
    do_reset();
    key_start = 1'b1;
    cyc("t3_sync", 2, 3'd5, 1'b0, 1'b0);
    cyc("t3_run5", 4, 3'd5, 1'b1, 1'b0);
    cyc("t3_run4", 4, 3'd4, 1'b1, 1'b0);
    cyc("t3_run3", 4, 3'd3, 1'b1, 1'b0);
    cyc("t3_run2", 4, 3'd2, 1'b1, 1'b0);
    cyc("t3_run1", 4, 3'd1, 1'b1, 1'b0);
    cyc("t3_done", 1, 3'd0, 1'b0, 1'b1);
    cyc("t3_hold", 27, 3'd0, 1'b0, 1'b0);
    key_start = 1'b0;
    cyc("t3_rel", 4, 3'd0, 1'b0, 1'b0);

    // 5: restart from DONE (continues from test 3's DONE state)
    key_start = 1'b1;
    cyc("t5_sync", 2, 3'd0, 1'b0, 1'b0);
    key_start = 1'b0;
    full_count("t5_count");

    // clear from DONE
    key_clr = 1'b1;
    cyc("clr_done_sync", 2, 3'd0, 1'b0, 1'b0);
    key_clr = 1'b0;
    cyc("clr_done", 4, 3'd5, 1'b0, 1'b0);

    // 4: clear and start together while running at num=2
    do_reset();
    key_start = 1'b1;
    cyc("t4_sync", 2, 3'd5, 1'b0, 1'b0);
    key_start = 1'b0;
    cyc("t4_run5", 4, 3'd5, 1'b1, 1'b0);
    cyc("t4_run4", 4, 3'd4, 1'b1, 1'b0);
    cyc("t4_run3", 4, 3'd3, 1'b1, 1'b0);
    key_start = 1'b1;
    key_clr   = 1'b1;
    cyc("t4_run2", 2, 3'd2, 1'b1, 1'b0);
    key_start = 1'b0;
    key_clr   = 1'b0;
    cyc("t4_clr", 12, 3'd5, 1'b0, 1'b0);

    // 6: asynchronous reset mid-prescaler at num=3
    do_reset();
    key_start = 1'b1;
    cyc("t6_sync", 2, 3'd5, 1'b0, 1'b0);
    key_start = 1'b0;
    cyc("t6_run5", 4, 3'd5, 1'b1, 1'b0);
    cyc("t6_run4", 4, 3'd4, 1'b1, 1'b0);
    cyc("t6_run3", 2, 3'd3, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_num", {29'd0, num}, 32'd5);
    check("t6_async_running", {31'd0, running}, 32'd0);
    check("t6_async_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc("t6_idle", 6, 3'd5, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
